// File: rtl/param_up_down_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : param_up_down_counter_pkg
//  Description : Shared encodings for the parametrised up/down counter and
//                its next-value calculator.
//  Revision    : 1.0  initial release
// ============================================================================
package param_up_down_counter_pkg;

    // Direction select carried on mode_i
    localparam logic MODE_UP    = 1'b1;
    localparam logic MODE_DOWN  = 1'b0;

    // Bound behaviour carried on sat_i
    localparam logic BOUND_WRAP = 1'b0;
    localparam logic BOUND_SAT  = 1'b1;

endpackage : param_up_down_counter_pkg
`default_nettype wire

// File: rtl/param_up_down_counter_ud_next_calc.sv
`default_nettype none
// ============================================================================
//  Module      : ud_next_calc
//  Description : Purely combinational next-count calculator. Given the
//                current count and an already-clamped step, produces the
//                next count for up/down, wrap/saturate operation together
//                with bound-hit, overflow-event and underflow-event strobes.
//  Revision    : 1.0  initial release
// ============================================================================
module ud_next_calc
    import param_up_down_counter_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int MAX_VAL = 2**WIDTH - 1
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic [WIDTH-1:0] step_i,     // caller guarantees step_i <= MAX_VAL
    input  logic             mode_i,
    input  logic             sat_i,
    output logic [WIDTH-1:0] next_o,
    output logic             bound_o,
    output logic             ovf_evt_o,
    output logic             unf_evt_o
);

    localparam logic [WIDTH-1:0] c_MAX     = WIDTH'(MAX_VAL);
    localparam logic [WIDTH:0]   c_MAX_EXT = (WIDTH+1)'(MAX_VAL);
    // Modulus of the count range; needs the extra bit when MAX_VAL = 2**WIDTH-1
    localparam logic [WIDTH:0]   c_MOD     = (WIDTH+1)'(MAX_VAL + 1);

    logic [WIDTH:0]   w_cnt_ext;
    logic [WIDTH:0]   w_step_ext;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_wrap_up;
    logic [WIDTH-1:0] w_wrap_dn;

    // All arithmetic is done one bit wider so the carry into the bound test
    // is never lost, then truncated once the result is known to be in range.
    assign w_cnt_ext  = {1'b0, count_i};
    assign w_step_ext = {1'b0, step_i};
    assign w_sum      = w_cnt_ext + w_step_ext;
    assign w_wrap_up  = WIDTH'(w_sum - c_MOD);
    assign w_wrap_dn  = WIDTH'(w_cnt_ext + c_MOD - w_step_ext);

    // Select next count and bound events from direction, step and bound mode
    always_comb begin
        next_o    = count_i;
        bound_o   = 1'b0;
        ovf_evt_o = 1'b0;
        unf_evt_o = 1'b0;
        if (step_i != '0) begin
            if (mode_i == MODE_UP) begin
                if (w_sum > c_MAX_EXT) begin
                    bound_o   = 1'b1;
                    ovf_evt_o = 1'b1;
                    next_o    = (sat_i == BOUND_SAT) ? c_MAX : w_wrap_up;
                end else begin
                    next_o    = w_sum[WIDTH-1:0];
                end
            end else begin
                if (w_step_ext > w_cnt_ext) begin
                    bound_o   = 1'b1;
                    unf_evt_o = 1'b1;
                    next_o    = (sat_i == BOUND_SAT) ? '0 : w_wrap_dn;
                end else begin
                    next_o    = count_i - step_i;
                end
            end
        end
    end

endmodule : ud_next_calc
`default_nettype wire

// File: rtl/param_up_down_counter.sv
`default_nettype none
// ============================================================================
//  Module      : param_up_down_counter
//  Description : Parametrised up/down counter with configurable width,
//                modulus and step. Supports synchronous load, count enable,
//                per-cycle wrap/saturate, a registered terminal-count pulse
//                and sticky overflow/underflow flags.
//  Revision    : 1.0  initial release
// ============================================================================
module param_up_down_counter
    import param_up_down_counter_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter int MAX_VAL   = 2**WIDTH - 1,
    parameter int RESET_VAL = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,        // asynchronous, active-low
    input  logic             en_i,
    input  logic             mode_i,
    input  logic             sat_i,
    input  logic [WIDTH-1:0] step_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             clr_flags_i,
    output logic [WIDTH-1:0] counter_o,
    output logic             tc_o,
    output logic             ovf_o,
    output logic             unf_o,
    output logic             at_max_o,
    output logic             at_min_o
);

    localparam logic [WIDTH-1:0] c_MAX   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] c_RESET = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] counter_q, counter_d;
    logic             tc_q,      tc_d;
    logic             ovf_q,     ovf_d;
    logic             unf_q,     unf_d;

    logic [WIDTH-1:0] w_step_eff;
    logic [WIDTH-1:0] w_load_eff;
    logic [WIDTH-1:0] w_calc_next;
    logic             w_calc_bound;
    logic             w_calc_ovf;
    logic             w_calc_unf;
    logic             w_count;

    // Steps and load values beyond the top of the range are clamped to it
    assign w_step_eff = (step_i     > c_MAX) ? c_MAX : step_i;
    assign w_load_eff = (load_val_i > c_MAX) ? c_MAX : load_val_i;

    // A counting edge is one where enable is set and no load overrides it
    assign w_count    = en_i & ~load_i;

    ud_next_calc #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_next_calc (
        .count_i   (counter_q),
        .step_i    (w_step_eff),
        .mode_i    (mode_i),
        .sat_i     (sat_i),
        .next_o    (w_calc_next),
        .bound_o   (w_calc_bound),
        .ovf_evt_o (w_calc_ovf),
        .unf_evt_o (w_calc_unf)
    );

    // Next state: load beats count beats hold; a new event beats a flag clear
    always_comb begin
        counter_d = counter_q;
        tc_d      = 1'b0;
        ovf_d     = ovf_q & ~clr_flags_i;
        unf_d     = unf_q & ~clr_flags_i;
        if (load_i) begin
            counter_d = w_load_eff;
        end else if (w_count) begin
            counter_d = w_calc_next;
            tc_d      = w_calc_bound;
            if (w_calc_ovf) begin
                ovf_d = 1'b1;
            end
            if (w_calc_unf) begin
                unf_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            counter_q <= c_RESET;
            tc_q      <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            counter_q <= counter_d;
            tc_q      <= tc_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign counter_o = counter_q;
    assign tc_o      = tc_q;
    assign ovf_o     = ovf_q;
    assign unf_o     = unf_q;

    // Bound indicators decode the register directly so they add no latency
    assign at_max_o  = (counter_q == c_MAX);
    assign at_min_o  = (counter_q == '0);

endmodule : param_up_down_counter
`default_nettype wire
